// File: rtl/mult_div_sequencer.sv
// ---------------------------------------------------------------------------
// mult_div_sequencer: 32-iteration signed MULT/DIV unit owning HI/LO. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult_div_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        op_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic        write_hi_i,
  input  logic        write_lo_i,
  input  logic [31:0] write_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        div_zero_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [4:0]  iter_count_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MULT_RUN = 2'd1,
    S_DIV_RUN  = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  localparam logic [4:0] c_LAST_ITER = 5'd31;

  state_e      state_q;
  logic [64:0] acc_q, acc_d;
  logic [31:0] b_mag_q;
  logic        neg_prod_q, neg_rem_q;
  logic [4:0]  iter_q;
  logic        busy_q, done_q, div_zero_q;
  logic [31:0] hi_q, lo_q;

  logic [31:0] w_a_mag, w_b_mag;
  logic [32:0] w_mult_sum;
  logic [32:0] w_div_shift;
  logic [33:0] w_div_diff;
  logic [32:0] w_div_rem;
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem;
  logic [31:0] w_res_hi, w_res_lo;

  // acc_q holds {carry/remainder, partial product/quotient}; MULT shifts right, DIV shifts left
  always_comb begin
    w_a_mag     = operand_a_i[31] ? (32'd0 - operand_a_i) : operand_a_i;
    w_b_mag     = operand_b_i[31] ? (32'd0 - operand_b_i) : operand_b_i;
    w_mult_sum  = acc_q[64:32] + (acc_q[0] ? {1'b0, b_mag_q} : 33'd0);
    w_div_shift = acc_q[63:31];
    w_div_diff  = {1'b0, w_div_shift} - {2'b00, b_mag_q};
    w_div_rem   = w_div_diff[33] ? w_div_shift : w_div_diff[32:0];
    acc_d       = acc_q;
    if (state_q == S_MULT_RUN) begin
      acc_d = {1'b0, w_mult_sum, acc_q[31:1]};
    end else if (state_q == S_DIV_RUN) begin
      acc_d = {w_div_rem, acc_q[30:0], ~w_div_diff[33]};
    end
    w_prod   = neg_prod_q ? (64'd0 - acc_d[63:0]) : acc_d[63:0];
    w_quo    = neg_prod_q ? (32'd0 - acc_d[31:0]) : acc_d[31:0];
    w_rem    = neg_rem_q ? (32'd0 - acc_d[63:32]) : acc_d[63:32];
    w_res_hi = (state_q == S_DIV_RUN) ? w_rem : w_prod[63:32];
    w_res_lo = (state_q == S_DIV_RUN) ? w_quo : w_prod[31:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      b_mag_q    <= '0;
      neg_prod_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      iter_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            iter_q <= '0;
            if (op_i && (operand_b_i == 32'd0)) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              div_zero_q <= 1'b1;
            end else begin
              state_q    <= op_i ? S_DIV_RUN : S_MULT_RUN;
              busy_q     <= 1'b1;
              acc_q      <= {33'd0, w_a_mag};
              b_mag_q    <= w_b_mag;
              neg_prod_q <= operand_a_i[31] ^ operand_b_i[31];
              neg_rem_q  <= operand_a_i[31];
            end
          end else begin
            if (write_hi_i) hi_q <= write_data_i;
            if (write_lo_i) lo_q <= write_data_i;
          end
        end
        S_MULT_RUN, S_DIV_RUN: begin
          acc_q <= acc_d;
          if (iter_q == c_LAST_ITER) begin
            hi_q    <= w_res_hi;
            lo_q    <= w_res_lo;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            iter_q  <= '0;
          end else begin
            iter_q <= iter_q + 5'd1;
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          done_q     <= 1'b0;
          div_zero_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign div_zero_o   = div_zero_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign iter_count_o = iter_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mult_div_sequencer: scoreboard bench for mult_div_sequencer. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mult_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, op;
  logic [31:0] opa, opb;
  logic        wr_hi, wr_lo;
  logic [31:0] wr_data;
  logic        busy, done, dz;
  logic [31:0] hi, lo;
  logic [4:0]  iter;

  mult_div_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .op_i         (op),
    .operand_a_i  (opa),
    .operand_b_i  (opb),
    .write_hi_i   (wr_hi),
    .write_lo_i   (wr_lo),
    .write_data_i (wr_data),
    .busy_o       (busy),
    .done_o       (done),
    .div_zero_o   (dz),
    .hi_o         (hi),
    .lo_o         (lo),
    .iter_count_o (iter)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          busy;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per Done pulse
  int busy_run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (busy !== 1'b1 && done !== 1'b1) busy_run = 0;
    if (busy === 1'b1) busy_run++;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_lo"}, lo, e.lo);
        check({e.name, "_divzero"}, dz, e.dz);
        check({e.name, "_done_cycle"}, cyc, e.cyc);
        check({e.name, "_busy_cycles"}, busy_run, e.busy);
        check({e.name, "_busy_with_done"}, busy, 64'd0);
      end
      busy_run = 0;
    end
  end

  task automatic issue(input string name, input logic o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic wl);
    exp_t e;
    logic z;
    z      = o && (b == 32'd0);
    e.name = name;
    e.hi   = ehi;
    e.lo   = elo;
    e.dz   = z;
    e.busy = z ? 0 : 32;
    e.cyc  = cyc + 1 + (z ? 0 : 32);
    sb.push_back(e);
    start = 1'b1; op = o; opa = a; opb = b; wr_lo = wl; wr_data = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check({name, "_timeout"}, 64'd1, 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input string name, input logic o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo);
    issue(name, o, a, b, ehi, elo, 1'b0);
    drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset held while start and both write strobes are also asserted
    rst = 1'b1; start = 1'b1; op = 1'b0; opa = 32'd3; opb = 32'd4;
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    rst = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_divzero", dz, 0);
    check("reset_iter", iter, 0);

    wr_hi = 1'b1; wr_data = 32'h0000_00AB;
    @(negedge clk);
    wr_hi = 1'b0;
    check("write_hi_only_hi", hi, 32'hAB);
    check("write_hi_only_lo", lo, 0);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h0000_CAFE;
    @(negedge clk);
    check("write_both_hi", hi, 32'hCAFE);
    check("write_both_lo", lo, 32'hCAFE);
    wr_lo = 1'b0; wr_data = 32'h11;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h22;
    @(negedge clk);
    wr_lo = 1'b0;
    check("preload_hi", hi, 32'h11);
    check("preload_lo", lo, 32'h22);

    run("div_5_by_0", 1'b1, 32'd5, 32'd0, 32'h11, 32'h22);
    issue("div_start_plus_writelo", 1'b1, 32'd9, 32'd0, 32'h11, 32'h22, 1'b1);
    drain("div_start_plus_writelo");

    run("mult_7_x_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // Abort a multiply mid-flight
    start = 1'b1; op = 1'b0; opa = 32'd7; opb = 32'hFFFF_FFFD;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (iter !== 5'd10 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("abort_iter_reached", iter, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_busy", busy, 0);
    check("abort_iter", iter, 0);
    repeat (40) @(negedge clk);
    check("abort_still_idle", busy, 0);

    run("mult_min_x_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run("div_m7_by_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_min_by_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run("mult_m1_x_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
    run("mult_max_x_max", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
    run("div_100_by_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
    run("div_7_by_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run("div_m100_by_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14);
    run("div_3_by_5", 1'b1, 32'd3, 32'd5, 32'd3, 32'd0);

    // Start and WriteHi during DONE must be ignored
    issue("mult_2_x_3", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    t = 0;
    while (done !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", done, 1);
    start = 1'b1; op = 1'b0; opa = 32'd5; opb = 32'd5; wr_hi = 1'b1; wr_data = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    check("start_in_done_busy", busy, 0);
    check("start_in_done_hi", hi, 0);
    check("start_in_done_lo", lo, 6);
    repeat (5) @(negedge clk);
    check("hold_busy", busy, 0);
    check("hold_hi", hi, 0);
    check("hold_lo", lo, 6);
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
